audio_dac_stream: RTL and testbench

Parametrised stereo audio output engine for the WM8731 codec on the DE1-SoC. It buffers stereo sample pairs from the HPS-side streaming interface in a FIFO and serialises them to the codec DAC as an I2S master, generating AUD_BCLK, AUD_DACLRCK and AUD_DACDAT. It also provides FIFO level, a sticky underrun flag and a low-watermark interrupt for the driver. It sits between the soc_system Avalon-ST source and the audio pins in soc_system_top, replacing the fixed-width read_data/source_ready/irq path.

---
 rtl/audio_dac_stream.sv | 192 +++++++++++++++++++
 tb/tb_audio_dac_stream.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_stream.sv
// -----------------------------------------------------------------------------
// audio_dac_stream
//
// Stereo audio output engine for the WM8731 codec. Stereo sample pairs from a
// valid/ready stream are buffered in a FIFO and serialised to the codec DAC as
// an I2S master (BCLK, DACLRCK, DACDAT). FIFO occupancy, a sticky underrun flag
// and a low-watermark interrupt are exported for the driver.
//
// Optional feature macro: AUDIO_DAC_STREAM_IRQ_EN
//   defined   : irq = irq_en && (level < LOW_WM), registered.
//   undefined : irq is held at 0; irq_en and LOW_WM have no effect.
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   enable        in   serialiser run; 0 holds the serial side idle
//   sample_data   in   {left, right}, two's complement, left in the MSBs
//   sample_valid  in   producer has an entry
//   sample_ready  out  FIFO can accept an entry
//   level         out  FIFO occupancy in stereo entries
//   underrun      out  sticky: a frame started with the FIFO empty
//   underrun_clr  in   clears underrun (wins over a same-cycle set)
//   irq_en        in   interrupt mask
//   irq           out  low-watermark interrupt
//   aud_bclk      out  I2S bit clock
//   aud_daclrck   out  0 = left slot, 1 = right slot
//   aud_dacdat    out  I2S serial data, changes on BCLK falling edges
// -----------------------------------------------------------------------------
module audio_dac_stream #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int FIFO_DEPTH = 64,
  parameter int BCLK_DIV   = 8,
  parameter int LOW_WM     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [2*SAMPLE_W-1:0]         sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          underrun,
  input  logic                          underrun_clr,
  input  logic                          irq_en,
  output logic                          irq,
  output logic                          aud_bclk,
  output logic                          aud_daclrck,
  output logic                          aud_dacdat
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int KW = $clog2(SLOT_W);
  localparam int BW = KW + 1;

  // Serial bit for slot position k: zero at k=0 (I2S one-bit delay), sample
  // MSB first for k=1..SAMPLE_W, zero padding afterwards.
  function automatic logic slot_bit(input logic signed [SAMPLE_W-1:0] s,
                                    input logic [KW-1:0] k);
    logic b;
    b = 1'b0;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (int'(k) == SAMPLE_W - i) b = s[i];
    end
    return b;
  endfunction

  logic [2*SAMPLE_W-1:0]  fifo_mem [FIFO_DEPTH];

  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   ready_q, ready_d;
  logic                   underrun_q, underrun_d;
  logic                   irq_q, irq_d;
  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic                   bclk_q, bclk_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   lrck_q, lrck_d;
  logic                   dat_q, dat_d;
  logic                   started_q, started_d;
  logic signed [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;

  logic push, pop, fall, div_end, frame_start;

  always_comb begin
    push        = sample_valid && ready_q;
    div_end     = (div_cnt_q == DW'(BCLK_DIV - 1));
    fall        = enable && bclk_q && div_end;
    // The first fall after enable opens a frame even though bit_cnt never wrapped.
    frame_start = fall && (!started_q || (bit_cnt_q == BW'(2*SLOT_W - 1)));
    // A push landing in an empty FIFO during frame start is not visible yet.
    pop         = frame_start && (level_q != '0);

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    ready_d  = (level_d != LW'(FIFO_DEPTH));

    underrun_d = underrun_q;
    if (frame_start && (level_q == '0)) underrun_d = 1'b1;
    if (underrun_clr)                   underrun_d = 1'b0;

    left_d  = left_q;
    right_d = right_q;
    if (pop) begin
      left_d  = $signed(fifo_mem[rd_ptr_q][2*SAMPLE_W-1:SAMPLE_W]);
      right_d = $signed(fifo_mem[rd_ptr_q][SAMPLE_W-1:0]);
    end else if (frame_start) begin
      left_d  = '0;
      right_d = '0;
    end

    // Disabled: everything serial returns to idle, aborting any frame.
    div_cnt_d = '0;
    bclk_d    = 1'b0;
    bit_cnt_d = '0;
    lrck_d    = 1'b0;
    dat_d     = 1'b0;
    started_d = 1'b0;
    if (enable) begin
      div_cnt_d = div_end ? '0 : div_cnt_q + DW'(1);
      bclk_d    = div_end ? !bclk_q : bclk_q;
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;
      dat_d     = dat_q;
      started_d = started_q;
      if (fall) begin
        started_d = 1'b1;
        bit_cnt_d = started_q ? bit_cnt_q + BW'(1) : '0;
        lrck_d    = bit_cnt_d[KW];
        // At k=0 the bit is 0 regardless, so the pre-latch sample is harmless.
        dat_d     = slot_bit(bit_cnt_d[KW] ? right_q : left_q, bit_cnt_d[KW-1:0]);
      end
    end
  end

`ifdef AUDIO_DAC_STREAM_IRQ_EN
  assign irq_d = irq_en && (level_q < LW'(LOW_WM));
`else
  logic unused_irq_cfg;
  assign irq_d          = 1'b0;
  assign unused_irq_cfg = irq_en ^ (LOW_WM < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b1;
      underrun_q <= 1'b0;
      irq_q      <= 1'b0;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      bit_cnt_q  <= '0;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
      irq_q      <= irq_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      bit_cnt_q  <= bit_cnt_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      started_q  <= started_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= sample_data;
    left_q  <= left_d;
    right_q <= right_d;
  end

  assign sample_ready = ready_q;
  assign level        = level_q;
  assign underrun     = underrun_q;
  assign irq          = irq_q;
  assign aud_bclk     = bclk_q;
  assign aud_daclrck  = lrck_q;
  assign aud_dacdat   = dat_q;

endmodule

// File: tb/tb_audio_dac_stream.sv
module tb_audio_dac_stream;

  localparam int SAMPLE_W = 16;
  localparam int LW       = 7;
`ifdef AUDIO_DAC_STREAM_IRQ_EN
  localparam logic IRQ_BUILT = 1'b1;
`else
  localparam logic IRQ_BUILT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  enable = 1'b0;
  logic [2*SAMPLE_W-1:0] sample_data = '0;
  logic                  sample_valid = 1'b0;
  logic                  sample_ready;
  logic [LW-1:0]         level;
  logic                  underrun;
  logic                  underrun_clr = 1'b0;
  logic                  irq_en = 1'b0;
  logic                  irq;
  logic                  aud_bclk, aud_daclrck, aud_dacdat;

  audio_dac_stream dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .level        (level),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .irq_en       (irq_en),
    .irq          (irq),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [1:0] exp_q [$];   // {lrck, dat} expected at each BCLK rise
  int         tag_q [$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  // Scoreboard entries for one enabled run: the lone rise before the first
  // frame, then 64 slot bits of a frame with the given left/right bit images.
  task automatic push_frame(input logic [31:0] l, input logic [31:0] r);
    exp_q.push_back(2'b00);
    tag_q.push_back(-1);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({1'b0, l[31-i]});
      tag_q.push_back(i);
    end
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({1'b1, r[31-i]});
      tag_q.push_back(32 + i);
    end
  endtask

  // Monitor: samples 1 time unit after each clk edge, compares on BCLK rises.
  initial begin : monitor
    logic [1:0] e;
    int         t;
    int         cyc;
    int         last_rise;
    logic       bclk_prev;
    cyc = 0;
    last_rise = -1;
    bclk_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset || !enable) begin
        last_rise = -1;
      end else if (aud_bclk && !bclk_prev) begin
        if (last_rise >= 0) check("bclk_period", cyc, cyc - last_rise, 16);
        last_rise = cyc;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          check("lrck_bit", t, aud_daclrck, e[1]);
          check("dat_bit", t, aud_dacdat, e[0]);
        end
      end
      bclk_prev = aud_bclk;
    end
  end

  initial begin : watchdog
    repeat (40000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; sample_valid = 1'b0; underrun_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    sample_data = d;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, -1, exp_q.size(), 0);
    exp_q.delete();
    tag_q.delete();
  endtask

  logic [31:0] l_img, r_img;

  initial begin : stimulus
    // Reset / idle
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", -1, sample_ready, 1);
    check("rst_level", -1, level, 0);
    check("rst_underrun", -1, underrun, 0);
    check("rst_irq", -1, irq, 0);
    check("rst_bclk", -1, aud_bclk, 0);
    check("rst_lrck", -1, aud_daclrck, 0);
    check("rst_dat", -1, aud_dacdat, 0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h1000 + i);
    check("idle_level3", -1, level, 3);
    repeat (20) @(negedge clk);
    check("idle_bclk", -1, aud_bclk, 0);

    // Serial format: {8001, 7FFE}
    do_reset();
    check("reset_empties", -1, level, 0);
    push(32'h8001_7FFE);
    check("serial_level1", -1, level, 1);
    @(negedge clk);
    enable = 1'b1;
    l_img = 32'h4000_8000;
    r_img = 32'h3FFF_0000;
    push_frame(l_img, r_img);
    repeat (17) @(negedge clk);
    check("first_pop_level", -1, level, 0);
    check("no_underrun", -1, underrun, 0);
    wait_drain("serial_drain");
    repeat (10) @(negedge clk);
    check("empty_frame_underrun", -1, underrun, 1);
    enable = 1'b0;

    // Underrun on the very first frame
    do_reset();
    enable = 1'b1;
    l_img = 32'h0;
    r_img = 32'h0;
    push_frame(l_img, r_img);
    repeat (18) @(negedge clk);
    check("underrun_set", -1, underrun, 1);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("underrun_clr", -1, underrun, 0);
    wait_drain("underrun_drain");
    enable = 1'b0;

    // Full
    do_reset();
    for (int i = 0; i < 64; i++) push(32'hA000_0000 + i);
    check("full_level", -1, level, 64);
    check("full_ready", -1, sample_ready, 0);
    push(32'hDEAD_BEEF);
    check("full_reject_level", -1, level, 64);
    check("full_reject_ready", -1, sample_ready, 0);

    // IRQ low watermark
    do_reset();
    irq_en = 1'b1;
    for (int i = 0; i < 17; i++) push(32'h0101_0101 * i);
    check("irq_level17", -1, level, 17);
    check("irq_above_wm", -1, irq, 0);
    @(negedge clk);
    enable = 1'b1;
    begin
      int i;
      for (i = 0; i < 2500 && level != 15; i++) @(negedge clk);
      check("irq_reach15", -1, level, 15);
    end
    check("irq_same_cycle", -1, irq, 0);
    @(negedge clk);
    check("irq_rise", -1, irq, IRQ_BUILT);
    enable = 1'b0;
    irq_en = 1'b0;

    // Abort mid right slot, then restart with the next entry
    do_reset();
    push(32'h8001_7FFE);
    push(32'hA5C3_0F0F);
    @(negedge clk);
    enable = 1'b1;
    begin
      int i;
      for (i = 0; i < 2000 && aud_daclrck != 1'b1; i++) @(negedge clk);
      check("abort_reach_right", -1, aud_daclrck, 1);
    end
    repeat (40) @(negedge clk);
    check("abort_level_before", -1, level, 1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_bclk", -1, aud_bclk, 0);
    check("abort_lrck", -1, aud_daclrck, 0);
    check("abort_dat", -1, aud_dacdat, 0);
    check("abort_level", -1, level, 1);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    l_img = 32'h52E1_8000;
    r_img = 32'h0787_8000;
    push_frame(l_img, r_img);
    wait_drain("restart_drain");
    check("restart_level", -1, level, 0);
    enable = 1'b0;

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
